// File: rtl/warp_bundle_queue.sv
// Warp bundle queue: circular buffer of decoded bundle pairs between decode and issue.
// Issue may consume a whole pair, or split it by taking only slot 0. A split leaves slot 1
// behind as a single-bundle head.

`ifndef BUNDLE_SIZE
`define BUNDLE_SIZE 32
`endif

module warp_bundle_queue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_flush,
    output logic                         o_input_ready,
    input  logic                         i_input_valid,
    input  logic [`BUNDLE_SIZE-1:0]      i_bundle0,
    input  logic [`BUNDLE_SIZE-1:0]      i_bundle1,
    input  logic                         i_bundle1_valid,
    input  logic                         i_output_ready,
    input  logic                         i_output_split,
    output logic                         o_output_valid,
    output logic [`BUNDLE_SIZE-1:0]      o_bundle0,
    output logic [`BUNDLE_SIZE-1:0]      o_bundle1,
    output logic                         o_bundle1_valid,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int unsigned W    = `BUNDLE_SIZE;
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

    logic [W-1:0]    bundle0_q [DEPTH];
    logic [W-1:0]    bundle1_q [DEPTH];
    logic            b1v_q     [DEPTH];
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q,  count_d;

    logic not_empty, full, head_b1v;
    logic do_enq, consume, do_split, do_deq;

    // Event decode; flush masks every other event.
    always_comb begin
        not_empty = (count_q != '0);
        full      = (count_q == FullCnt);
        head_b1v  = b1v_q[rd_ptr_q];
        do_enq    = i_input_valid && !full && !i_flush;
        consume   = not_empty && i_output_ready && !i_flush;
        // A split on a single-bundle head degenerates to a full dequeue.
        do_split  = consume && i_output_split && head_b1v;
        do_deq    = consume && !do_split;
    end

    // Pointer and occupancy next-state.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (i_flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_enq) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (do_deq) rd_ptr_d = rd_ptr_q + PtrW'(1);
            if (do_enq && !do_deq)      count_d = count_q + CntW'(1);
            else if (do_deq && !do_enq) count_d = count_q - CntW'(1);
        end
    end

    // Control state with asynchronous clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Slot-1 valid flags; cleared on reset, dropped on the head when it is split.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) b1v_q[i] <= 1'b0;
        end else begin
            if (do_enq)   b1v_q[wr_ptr_q] <= i_bundle1_valid;
            if (do_split) b1v_q[rd_ptr_q] <= 1'b0;
        end
    end

    // Bundle payload needs no reset: outputs are gated while the queue is empty.
    // Enqueue and split never hit the same slot since enqueue needs a non-full queue.
    always_ff @(posedge i_clk) begin
        if (do_enq) begin
            bundle0_q[wr_ptr_q] <= i_bundle0;
            bundle1_q[wr_ptr_q] <= i_bundle1_valid ? i_bundle1 : '0;
        end
        if (do_split) begin
            bundle0_q[rd_ptr_q] <= bundle1_q[rd_ptr_q];
            bundle1_q[rd_ptr_q] <= '0;
        end
    end

    // Head presentation, zeroed while empty.
    always_comb begin
        o_input_ready   = !full;
        o_output_valid  = not_empty;
        o_count         = count_q;
        o_bundle0       = not_empty ? bundle0_q[rd_ptr_q] : '0;
        o_bundle1       = not_empty ? bundle1_q[rd_ptr_q] : '0;
        o_bundle1_valid = not_empty && head_b1v;
    end

endmodule

// File: tb/tb_warp_bundle_queue.sv
// Directed self-checking bench for warp_bundle_queue (DEPTH=4).

`ifndef BUNDLE_SIZE
`define BUNDLE_SIZE 32
`endif

module tb_warp_bundle_queue;

    localparam int unsigned W = `BUNDLE_SIZE;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic         in_ready;
    logic         in_valid;
    logic [W-1:0] in_b0, in_b1;
    logic         in_b1v;
    logic         out_ready, out_split;
    logic         out_valid;
    logic [W-1:0] out_b0, out_b1;
    logic         out_b1v;
    logic [2:0]   count;

    int checks   = 0;
    int failures = 0;

    warp_bundle_queue #(.DEPTH(4)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_flush         (flush),
        .o_input_ready   (in_ready),
        .i_input_valid   (in_valid),
        .i_bundle0       (in_b0),
        .i_bundle1       (in_b1),
        .i_bundle1_valid (in_b1v),
        .i_output_ready  (out_ready),
        .i_output_split  (out_split),
        .o_output_valid  (out_valid),
        .o_bundle0       (out_b0),
        .o_bundle1       (out_b1),
        .o_bundle1_valid (out_b1v),
        .o_count         (count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_b0     = '0;
        in_b1     = '0;
        in_b1v    = 1'b0;
        out_ready = 1'b0;
        out_split = 1'b0;
    endtask

    task automatic drive_pair(input logic [W-1:0] b0, input logic [W-1:0] b1, input logic b1v);
        in_valid = 1'b1;
        in_b0    = b0;
        in_b1    = b1;
        in_b1v   = b1v;
    endtask

    task automatic enq(input logic [W-1:0] b0, input logic [W-1:0] b1, input logic b1v);
        drive_pair(b0, b1, b1v);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic deq();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic check_head(input string tag, input logic [W-1:0] b0,
                              input logic [W-1:0] b1, input logic b1v);
        check_eq({tag, ".valid"}, 64'(out_valid), 64'd1);
        check_eq({tag, ".b0"}, 64'(out_b0), 64'(b0));
        check_eq({tag, ".b1"}, 64'(out_b1), 64'(b1));
        check_eq({tag, ".b1v"}, 64'(out_b1v), 64'(b1v));
    endtask

    task automatic check_empty(input string tag);
        check_eq({tag, ".count"}, 64'(count), 64'd0);
        check_eq({tag, ".ovalid"}, 64'(out_valid), 64'd0);
        check_eq({tag, ".iready"}, 64'(in_ready), 64'd1);
        check_eq({tag, ".b0"}, 64'(out_b0), 64'd0);
        check_eq({tag, ".b1"}, 64'(out_b1), 64'd0);
        check_eq({tag, ".b1v"}, 64'(out_b1v), 64'd0);
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        #2;
        check_empty("reset");
        tick();
        tick();
        rst_n = 1'b1;

        // Fill A..E; no same-cycle bypass into an empty queue.
        drive_pair(32'hA0, 32'hA1, 1'b1);
        #1;
        check_eq("nobypass.ovalid", 64'(out_valid), 64'd0);
        tick();
        check_eq("fill.cnt1", 64'(count), 64'd1);
        check_head("fill.headA", 32'hA0, 32'hA1, 1'b1);
        enq(32'hB0, 32'hB1, 1'b1);
        check_eq("fill.cnt2", 64'(count), 64'd2);
        enq(32'hC0, 32'hC1, 1'b1);
        check_eq("fill.cnt3", 64'(count), 64'd3);
        enq(32'hD0, 32'hD1, 1'b1);
        check_eq("fill.cnt4", 64'(count), 64'd4);
        check_eq("fill.notready", 64'(in_ready), 64'd0);
        enq(32'hE0, 32'hE1, 1'b1);
        check_eq("fill.Edropped", 64'(count), 64'd4);
        check_head("fill.stillA", 32'hA0, 32'hA1, 1'b1);

        // Drain four, in order.
        deq();
        check_head("drain.B", 32'hB0, 32'hB1, 1'b1);
        check_eq("drain.readyback", 64'(in_ready), 64'd1);
        deq();
        check_head("drain.C", 32'hC0, 32'hC1, 1'b1);
        deq();
        check_head("drain.D", 32'hD0, 32'hD1, 1'b1);
        deq();
        check_empty("drain.empty");

        // Six more through the wrapping pointers; odd ones carry a single bundle.
        for (int i = 0; i < 6; i++) begin
            logic [W-1:0] b0;
            logic [W-1:0] b1;
            logic         v;
            b0 = W'(32'h100 + i);
            b1 = W'(32'hDEAD0 + i);
            v  = (i % 2 == 0);
            enq(b0, b1, v);
            check_head($sformatf("wrap%0d", i), b0, v ? b1 : '0, v);
            deq();
            check_eq($sformatf("wrap%0d.cnt", i), 64'(count), 64'd0);
        end
        check_empty("wrap.empty");

        // Empty queue ignores ready/split.
        out_ready = 1'b1;
        out_split = 1'b1;
        tick();
        idle_inputs();
        check_empty("emptyignore");

        // Split then full dequeue of the leftover.
        enq(32'h11, 32'h22, 1'b1);
        out_ready = 1'b1;
        out_split = 1'b1;
        tick();
        check_head("split.left", 32'h22, 32'h0, 1'b0);
        check_eq("split.cnt", 64'(count), 64'd1);
        tick(); // split on single-bundle head behaves as full dequeue
        idle_inputs();
        check_empty("split.done");

        // Simultaneous enqueue+dequeue at count=2.
        enq(32'h50, 32'h51, 1'b1);
        enq(32'h60, 32'h61, 1'b1);
        drive_pair(32'h70, 32'h71, 1'b1);
        out_ready = 1'b1;
        tick();
        idle_inputs();
        check_eq("simul.cnt2", 64'(count), 64'd2);
        check_head("simul.Q", 32'h60, 32'h61, 1'b1);
        deq();
        check_head("simul.R", 32'h70, 32'h71, 1'b1);
        deq();
        check_empty("simul.empty");

        // Same stimulus at count=4: enqueue dropped.
        for (int i = 0; i < 4; i++) enq(W'(32'h80 + i), W'(32'h90 + i), 1'b1);
        drive_pair(32'hF0, 32'hF1, 1'b1);
        out_ready = 1'b1;
        tick();
        idle_inputs();
        check_eq("fullsimul.cnt3", 64'(count), 64'd3);
        check_head("fullsimul.S1", 32'h81, 32'h91, 1'b1);
        deq();
        deq();
        check_head("fullsimul.S3", 32'h83, 32'h93, 1'b1);
        deq();
        check_empty("fullsimul.noF");

        // Flush beats a same-cycle enqueue and dequeue.
        for (int i = 0; i < 3; i++) enq(W'(32'hC00 + i), '0, 1'b0);
        check_eq("flush.pre", 64'(count), 64'd3);
        drive_pair(32'hCAFE, 32'hBEEF, 1'b1);
        out_ready = 1'b1;
        flush     = 1'b1;
        tick();
        idle_inputs();
        check_empty("flush");

        // Asynchronous reset between edges with two entries.
        enq(32'h31, 32'h32, 1'b1);
        enq(32'h41, 32'h42, 1'b1);
        check_eq("areset.pre", 64'(count), 64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check_empty("areset");
        tick();
        rst_n = 1'b1;
        enq(32'h5A, 32'h5B, 1'b0);
        check_eq("areset.first", 64'(count), 64'd1);
        check_head("areset.head", 32'h5A, 32'h0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time bound in case the stimulus ever stalls.
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
